pivot_op_issuer: RTL and testbench
==================================

Name: pivot_op_issuer

Overview:
- Diagonal (pivot) cell of the single-pass GF(2^m) systemizer row.
- Consumes the pivot-column element of each streamed row and decides the row operation: pass, inv-add or add.
- Issues the 2-bit op code and the GF factor that the downstream chain of elimination cells (op_in/fac_in/start_in interface) applies to the rest of the row.
- Computes the pivot inverse iteratively with a single combinational GF multiplier.

Parameters:
- WIDTH, 13, field degree m; element width in bits; legal range 2..16.
- POLY, 13'h001B, reduction polynomial without its implicit x^WIDTH term (default x^13+x^4+x^3+x+1).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- start_in  in  1  qualifies the accepted row as row 0 of a new matrix.
- din_valid  in  1  row element present.
- din_ready  out  1  block can accept an element.
- din  in  WIDTH  pivot-column element of the current row.
- op_valid  out  1  one-cycle strobe; op_out/fac_out/start_out are valid.
- op_out  out  2  00 pass, 01 swap (never issued), 10 add, 11 inv-add.
- fac_out  out  WIDTH  factor for downstream cells.
- start_out  out  1  start_in of the row that produced this op.
- pivot_found  out  1  a pivot is held for the current matrix.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - din_ready=1 after reset release; op_valid=0, op_out=00, fac_out=0, start_out=0, pivot_found=0.
  - Multiplier sequencer cleared.
- States: IDLE, INV.
- Accept = din_valid & din_ready. din_ready=1 only in IDLE.
- No downstream backpressure; op_valid pulses exactly once per accepted element.
- On accept, effective flag pf = start_in ? 0 : pivot_found.
- Case pf=1:
  - Next cycle: op_valid=1, op_out=10, fac_out=din, start_out=start_in. Latency 1.
- Case pf=0 and din=0:
  - Next cycle: op_valid=1, op_out=00, fac_out=0, start_out=start_in.
  - pivot_found<=0.
- Case pf=0 and din!=0:
  - Capture a=din and start_in; enter INV; din_ready=0.
  - Inversion computes a^(2^m-2):
    - t=a.
    - Repeat WIDTH-2 times: t=t^2 (one cycle), then t=t*a (one cycle).
    - Final t=t^2 (one cycle).
  - INV lasts L=2*(WIDTH-2)+1 cycles (23 for WIDTH=13).
  - Cycle after the last INV cycle: op_valid=1, op_out=11, fac_out=a^-1, start_out=captured start, pivot_found<=1.
  - State returns to IDLE in that same cycle; din_ready=1 in that cycle.
- op_out/fac_out hold their last values between strobes. Only op_valid qualifies them.
- GF multiply: carry-less product of two WIDTH-bit operands, reduced by POLY. Combinational, one per cycle.
- start_in with pf held: the pivot is discarded before the row is evaluated. A new matrix never inherits a pivot.
- din_valid while in INV is ignored; the producer must hold it.
- rst asserted mid-INV aborts the inversion. No op_valid is issued for the aborted row.

Optional Feature:
- Macro: SYSTEMIZER_FAIL_DETECT_EN.
- With the macro, extra ports are added:
  - last_in (in, 1): marks the final row of a matrix, sampled on accept.
  - fail_out (out, 1): sticky.
- fail_out sets when the op for a last_in row issues with pivot_found=0 after that op. It is set on the cycle of that op_valid.
- fail_out clears on reset or on accept of a start_in row.
- Without the macro: ports absent, no fail logic.

Decomposition:
- Shared package systemizer_pkg:
  - Op-code constants OP_PASS=2'b00, OP_SWAP=2'b01, OP_ADD=2'b10, OP_INVADD=2'b11.
  - Function inv_latency(WIDTH)=2*(WIDTH-2)+1.
- One sub-module: gf_mul_comb, a combinational GF(2^WIDTH) multiplier parameterised by WIDTH and POLY. It is used for both squaring and multiply steps.

Test Plan:
- WIDTH=4, POLY=4'h3; start_in=1, din=0x2 -> din_ready low for 5 cycles; next cycle op_valid=1, op_out=11, fac_out=0x9, start_out=1, pivot_found=1.
- Following accept din=0x7, start_in=0 -> next cycle op_valid=1, op_out=10, fac_out=0x7, start_out=0.
- Accept start_in=1, din=0x0 while pivot_found=1 -> next cycle op_out=00, fac_out=0, start_out=1, pivot_found=0.
- Exhaustive: every nonzero a in GF(16) in fresh matrices -> fac_out*a=1 for each. Repeat WIDTH=13 default with 64 random a; latency 23.
- rst pulsed low on INV cycle 3 -> outputs take reset values immediately; no op_valid; next accept behaves as a fresh matrix.
- With SYSTEMIZER_FAIL_DETECT_EN: rows 0x0,0x0,0x0 (last_in on third) -> fail_out=1 with third op_valid. Next start_in accept -> fail_out=0.

Source files
------------

// File: rtl/systemizer_pkg.sv
// rtl/systemizer_pkg.sv - shared op codes, FSM state type and latency helper for the systemizer row
//
// Purpose: definitions shared by the pivot issuer and the downstream elimination cells.
//   OP_*            2-bit row operation codes carried on op_out/op_in.
//   issuer_state_t  state encoding of the pivot issuer.
//   inv_latency()   number of INV cycles needed to invert one element of GF(2^width).
package systemizer_pkg;

  localparam logic [1:0] OP_PASS   = 2'b00;
  localparam logic [1:0] OP_SWAP   = 2'b01;
  localparam logic [1:0] OP_ADD    = 2'b10;
  localparam logic [1:0] OP_INVADD = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_INV  = 1'b1
  } issuer_state_t;

  // a^(2^m-2): (m-2) square+multiply pairs followed by one final square.
  function automatic int inv_latency(input int width);
    return 2 * (width - 2) + 1;
  endfunction

endpackage

// File: rtl/gf_mul_comb.sv
// rtl/gf_mul_comb.sv - combinational GF(2^WIDTH) multiplier
//
// Purpose: p = a * b in GF(2^WIDTH), reduced by x^WIDTH + POLY.
// Ports:
//   a  in  WIDTH  first operand
//   b  in  WIDTH  second operand
//   p  out WIDTH  reduced product
module gf_mul_comb #(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] POLY  = 13'h001B
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] p
);

  logic [WIDTH-1:0] acc;

  // Horner form, MSB of b first: shift the partial result up one degree,
  // fold the overflowing x^WIDTH term back in via POLY, then add a if b[i] is set.
  always_comb begin
    acc = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc = {acc[WIDTH-2:0], 1'b0} ^ (acc[WIDTH-1] ? POLY : '0) ^ (b[i] ? a : '0);
    end
    p = acc;
  end

endmodule

// File: rtl/pivot_op_issuer.sv
// rtl/pivot_op_issuer.sv - diagonal pivot cell: decides pass/add/inv-add per row and issues the GF factor
//
// Purpose: consumes the pivot-column element of each streamed row and issues one
//   op/factor strobe per accepted element for the downstream elimination chain.
//   A nonzero element arriving without a held pivot becomes the pivot; its inverse
//   is computed over inv_latency(WIDTH) cycles with a single shared GF multiplier.
// Optional build macro: SYSTEMIZER_FAIL_DETECT_EN adds last_in / fail_out.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   start_in     in   accepted row is row 0 of a new matrix
//   din_valid    in   row element present
//   din_ready    out  element can be accepted (IDLE only)
//   din          in   WIDTH pivot-column element
//   op_valid     out  one-cycle strobe qualifying op_out/fac_out/start_out
//   op_out       out  2 op code (00 pass, 10 add, 11 inv-add)
//   fac_out      out  WIDTH factor for downstream cells
//   start_out    out  start_in of the row that produced this op
//   pivot_found  out  a pivot is held for the current matrix
//   last_in      in   (macro) final row of the matrix, sampled on accept
//   fail_out     out  (macro) sticky: last row issued without a pivot
module pivot_op_issuer
  import systemizer_pkg::*;
#(
  parameter int               WIDTH = 13,
  parameter logic [WIDTH-1:0] POLY  = 13'h001B
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_in,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [WIDTH-1:0] din,
  output logic             op_valid,
  output logic [1:0]       op_out,
  output logic [WIDTH-1:0] fac_out,
  output logic             start_out,
  output logic             pivot_found
`ifdef SYSTEMIZER_FAIL_DETECT_EN
  ,
  input  logic             last_in,
  output logic             fail_out
`endif
);

  localparam int INV_LAT = inv_latency(WIDTH);
  localparam int CW      = (INV_LAT > 1) ? $clog2(INV_LAT) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(INV_LAT - 1);

  issuer_state_t    state, state_nxt;
  logic [CW-1:0]    step;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] t_reg;
  logic [WIDTH-1:0] mul_b;
  logic [WIDTH-1:0] mul_p;
  logic             start_cap;
  logic             accept;
  logic             pf_eff;

  assign accept = din_valid & din_ready;
  // A start_in row never sees the previous matrix's pivot.
  assign pf_eff = ~start_in & pivot_found;

  // Even steps square t, odd steps multiply by a; INV_LAT is odd so the
  // sequence ends on the final square.
  assign mul_b = step[0] ? a_reg : t_reg;

  gf_mul_comb #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_mul (
    .a (t_reg),
    .b (mul_b),
    .p (mul_p)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    din_ready = (state == ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (din_valid && !pf_eff && (din != '0)) begin
          state_nxt = ST_INV;
        end
      end
      ST_INV: begin
        if (step == LAST_STEP) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step        <= '0;
      a_reg       <= '0;
      t_reg       <= '0;
      start_cap   <= 1'b0;
      op_valid    <= 1'b0;
      op_out      <= OP_PASS;
      fac_out     <= '0;
      start_out   <= 1'b0;
      pivot_found <= 1'b0;
    end else begin
      op_valid <= 1'b0;
      if (accept) begin
        if (pf_eff) begin
          op_valid  <= 1'b1;
          op_out    <= OP_ADD;
          fac_out   <= din;
          start_out <= start_in;
        end else begin
          pivot_found <= 1'b0;
          if (din == '0) begin
            op_valid  <= 1'b1;
            op_out    <= OP_PASS;
            fac_out   <= '0;
            start_out <= start_in;
          end else begin
            a_reg     <= din;
            t_reg     <= din;
            step      <= '0;
            start_cap <= start_in;
          end
        end
      end else if (state == ST_INV) begin
        t_reg <= mul_p;
        step  <= step + 1'b1;
        if (step == LAST_STEP) begin
          op_valid    <= 1'b1;
          op_out      <= OP_INVADD;
          fac_out     <= mul_p;
          start_out   <= start_cap;
          pivot_found <= 1'b1;
        end
      end
    end
  end

`ifdef SYSTEMIZER_FAIL_DETECT_EN
  // Only a pass op leaves pivot_found low, so a failing last row is always
  // issued on the accept edge. Set has priority over the start_in clear so a
  // single-row all-zero matrix still reports failure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_out <= 1'b0;
    end else begin
      if (accept && start_in) begin
        fail_out <= 1'b0;
      end
      if (accept && !pf_eff && (din == '0) && last_in) begin
        fail_out <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pivot_op_issuer.sv
// tb/tb_pivot_op_issuer.sv - self-checking bench for pivot_op_issuer (GF(16) and GF(2^13) instances)
module tb_pivot_op_issuer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // GF(16) instance, POLY x^4+x+1
  logic       rst4 = 1'b0;
  logic       start_in4 = 1'b0, din_valid4 = 1'b0, din_ready4;
  logic [3:0] din4 = '0;
  logic       op_valid4, start_out4, pivot_found4;
  logic [1:0] op_out4;
  logic [3:0] fac_out4;
`ifdef SYSTEMIZER_FAIL_DETECT_EN
  logic       last_in4 = 1'b0, fail_out4;
  bit         fail4_m = 0;
`endif

  // GF(2^13) default instance
  logic        rst13 = 1'b0;
  logic        start_in13 = 1'b0, din_valid13 = 1'b0, din_ready13;
  logic [12:0] din13 = '0;
  logic        op_valid13, start_out13, pivot_found13;
  logic [1:0]  op_out13;
  logic [12:0] fac_out13;
`ifdef SYSTEMIZER_FAIL_DETECT_EN
  logic        last_in13 = 1'b0, fail_out13;
`endif

  bit pf4 = 0;

  pivot_op_issuer #(.WIDTH(4), .POLY(4'h3)) dut4 (
    .clk(clk), .rst(rst4), .start_in(start_in4), .din_valid(din_valid4),
    .din_ready(din_ready4), .din(din4), .op_valid(op_valid4), .op_out(op_out4),
    .fac_out(fac_out4), .start_out(start_out4), .pivot_found(pivot_found4)
`ifdef SYSTEMIZER_FAIL_DETECT_EN
    , .last_in(last_in4), .fail_out(fail_out4)
`endif
  );

  pivot_op_issuer dut13 (
    .clk(clk), .rst(rst13), .start_in(start_in13), .din_valid(din_valid13),
    .din_ready(din_ready13), .din(din13), .op_valid(op_valid13), .op_out(op_out13),
    .fac_out(fac_out13), .start_out(start_out13), .pivot_found(pivot_found13)
`ifdef SYSTEMIZER_FAIL_DETECT_EN
    , .last_in(last_in13), .fail_out(fail_out13)
`endif
  );

  // Reference field arithmetic: full carry-less product, then long division by x^w + poly.
  function automatic int gfmul(input int a, input int b, input int w, input int poly);
    int prod = 0;
    for (int i = 0; i < w; i++) if (b[i]) prod ^= (a << i);
    for (int i = 2 * w - 2; i >= w; i--) if (prod[i]) prod ^= (((1 << w) | poly) << (i - w));
    return prod;
  endfunction

  function automatic int gfinv(input int a, input int w, input int poly);
    for (int b = 1; b < (1 << w); b++) if (gfmul(a, b, w, poly) == 1) return b;
    return 0;
  endfunction

  // Offer one row to dut4, then wait for its op strobe and check it against the model.
  task automatic send4(input bit s, input int d, input bit l);
    int lat, rdy_low, exp_lat, efac, w;
    logic [1:0] eop;
    w = 0;
    while (din_ready4 !== 1'b1 && w < 40) begin @(posedge clk); #1; w++; end
    n_cmp++;
    if (din_ready4 !== 1'b1) begin
      n_fail++; $display("FAIL ready_timeout: din_ready=%b required 1", din_ready4); return;
    end
    start_in4 = s; din4 = d[3:0]; din_valid4 = 1'b1;
`ifdef SYSTEMIZER_FAIL_DETECT_EN
    last_in4 = l;
`endif
    @(posedge clk); #1;
    din_valid4 = 1'b0;
    if (!s && pf4) begin
      eop = 2'b10; efac = d; exp_lat = 0;
    end else if (d == 0) begin
      eop = 2'b00; efac = 0; exp_lat = 0; pf4 = 0;
    end else begin
      eop = 2'b11; efac = gfinv(d, 4, 3); exp_lat = 5; pf4 = 1;
    end
`ifdef SYSTEMIZER_FAIL_DETECT_EN
    if (s) fail4_m = 0;
    if (l && !pf4) fail4_m = 1;
`endif
    lat = 0; rdy_low = 0;
    while (op_valid4 !== 1'b1 && lat < 40) begin
      if (din_ready4 === 1'b0) rdy_low++;
      @(posedge clk); #1; lat++;
    end
    n_cmp++;
    if (lat !== exp_lat) begin
      n_fail++; $display("FAIL op_latency: got %0d cycles required %0d (din=%h)", lat, exp_lat, d);
    end
    n_cmp++;
    if (rdy_low !== exp_lat) begin
      n_fail++; $display("FAIL ready_low_cycles: got %0d required %0d", rdy_low, exp_lat);
    end
    if (op_valid4 !== 1'b1) return;
    n_cmp++;
    if ({op_out4, fac_out4, start_out4, pivot_found4} !== {eop, efac[3:0], s, pf4}) begin
      n_fail++;
      $display("FAIL op_fields: got op=%b fac=%h start=%b pf=%b required op=%b fac=%h start=%b pf=%b",
               op_out4, fac_out4, start_out4, pivot_found4, eop, efac[3:0], s, pf4);
    end
`ifdef SYSTEMIZER_FAIL_DETECT_EN
    n_cmp++;
    if (fail_out4 !== fail4_m) begin
      n_fail++; $display("FAIL fail_out: got %b required %b", fail_out4, fail4_m);
    end
`endif
  endtask

  // Idle cycles: strobe must stay low and op/fac must hold.
  task automatic idle4(input int n);
    logic [1:0] pop;
    logic [3:0] pfac;
    pop = op_out4; pfac = fac_out4;
    repeat (n) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({op_valid4, op_out4, fac_out4} !== {1'b0, pop, pfac}) begin
        n_fail++;
        $display("FAIL idle_hold: got v=%b op=%b fac=%h required v=0 op=%b fac=%h",
                 op_valid4, op_out4, fac_out4, pop, pfac);
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if ({op_valid4, op_out4, fac_out4, start_out4, pivot_found4} !== 9'b0) begin
      n_fail++; $display("FAIL reset_outputs4: got %b required 0",
                         {op_valid4, op_out4, fac_out4, start_out4, pivot_found4});
    end
    n_cmp++;
    if ({op_valid13, op_out13, fac_out13, start_out13, pivot_found13} !== 18'b0) begin
      n_fail++; $display("FAIL reset_outputs13: got %b required 0",
                         {op_valid13, op_out13, fac_out13, start_out13, pivot_found13});
    end
    rst4 = 1'b1; rst13 = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({din_ready4, din_ready13} !== 2'b11) begin
      n_fail++; $display("FAIL reset_ready: got %b required 11", {din_ready4, din_ready13});
    end
  endtask

  task automatic test_directed;
    send4(1, 2, 0);
    n_cmp++;
    if (fac_out4 !== 4'h9) begin
      n_fail++; $display("FAIL inv_of_2: got %h required 9", fac_out4);
    end
    send4(0, 7, 0);
    send4(1, 0, 0);
    n_cmp++;
    if (pivot_found4 !== 1'b0) begin
      n_fail++; $display("FAIL start_discards_pivot: got %b required 0", pivot_found4);
    end
    idle4(2);
  endtask

  task automatic test_exhaustive_inv;
    for (int a = 1; a < 16; a++) begin
      send4(1, a, 0);
      n_cmp++;
      if (gfmul(int'(fac_out4), a, 4, 3) !== 1) begin
        n_fail++; $display("FAIL inv_product4: a=%h fac=%h product=%h required 1",
                           a, fac_out4, gfmul(int'(fac_out4), a, 4, 3));
      end
    end
  endtask

  task automatic test_inv13;
    for (int k = 0; k < 64; k++) begin
      int a, lat;
      a = $urandom_range(8191, 1);
      start_in13 = 1'b1; din13 = a[12:0]; din_valid13 = 1'b1;
      @(posedge clk); #1;
      din_valid13 = 1'b0;
      lat = 0;
      while (op_valid13 !== 1'b1 && lat < 60) begin @(posedge clk); #1; lat++; end
      n_cmp++;
      if (lat !== 23) begin
        n_fail++; $display("FAIL latency13: a=%h got %0d required 23", a, lat);
      end
      n_cmp++;
      if ({op_out13, start_out13, pivot_found13} !== 4'b1111 ||
          gfmul(int'(fac_out13), a, 13, 'h1B) !== 1) begin
        n_fail++; $display("FAIL inv13: a=%h fac=%h op=%b start=%b pf=%b required product 1 op=11 start=1 pf=1",
                           a, fac_out13, op_out13, start_out13, pivot_found13);
      end
    end
    start_in13 = 1'b0;
  endtask

  task automatic test_mid_inv_reset;
    int seen;
    start_in4 = 1'b1; din4 = 4'hB; din_valid4 = 1'b1;
    @(posedge clk); #1;
    din_valid4 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst4 = 1'b0;
    #1;
    n_cmp++;
    if ({op_valid4, op_out4, fac_out4, start_out4, pivot_found4, din_ready4} !== 10'b1) begin
      n_fail++; $display("FAIL mid_inv_reset: got %b required 0000000001",
                         {op_valid4, op_out4, fac_out4, start_out4, pivot_found4, din_ready4});
    end
    @(posedge clk); #1;
    rst4 = 1'b1;
    pf4 = 0;
`ifdef SYSTEMIZER_FAIL_DETECT_EN
    fail4_m = 0;
`endif
    seen = 0;
    repeat (30) begin @(posedge clk); #1; if (op_valid4 !== 1'b0) seen++; end
    n_cmp++;
    if (seen !== 0) begin
      n_fail++; $display("FAIL aborted_row_strobe: got %0d strobes required 0", seen);
    end
    send4(0, 7, 0);
  endtask

  task automatic test_fail_detect;
`ifdef SYSTEMIZER_FAIL_DETECT_EN
    send4(1, 0, 0);
    send4(0, 0, 0);
    send4(0, 0, 1);
    n_cmp++;
    if (fail_out4 !== 1'b1) begin
      n_fail++; $display("FAIL fail_set: got %b required 1", fail_out4);
    end
    send4(1, 5, 0);
    n_cmp++;
    if (fail_out4 !== 1'b0) begin
      n_fail++; $display("FAIL fail_clear: got %b required 0", fail_out4);
    end
`endif
  endtask

  task automatic test_random;
    for (int k = 0; k < 300; k++) begin
      bit s, l;
      int d;
      s = ($urandom % 6 == 0);
      d = ($urandom % 3 == 0) ? 0 : int'($urandom % 16);
      l = ($urandom % 4 == 0);
      send4(s, d, l);
      if ($urandom % 2) idle4(int'($urandom % 3) + 1);
    end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 40; k++) begin
      send4(k % 8 == 0, (k % 5 == 2) ? 0 : int'($urandom % 16), k % 8 == 7);
    end
    idle4(1);
  endtask

  initial begin
    test_reset;
    test_directed;
    test_exhaustive_inv;
    test_inv13;
    test_mid_inv_reset;
    test_fail_detect;
    test_random;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
